// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage IEEE-754 single-precision to signed 32-bit integer
// converter. Stage 1 classifies the operand and precomputes the shift;
// stage 2 shifts, rounds, applies the sign and saturates into the output
// registers. A global stall freezes every register; rst clears the valid
// chain and the visible outputs.
module ftoi_pipe #(
  parameter int ROUND_MODE = 0  // 0: nearest, ties away from zero; 1: toward zero
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic [31:0] a,
  output logic        out_valid,
  output logic [31:0] b,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [2:0] {
    CL_ZERO,     // e == 0: zero or denormal
    CL_SMALL,    // 1 <= e <= 125: magnitude below 0.5
    CL_HALF,     // e == 126: magnitude in [0.5, 1)
    CL_NORMAL,   // 127 <= e <= 157: fits in 31 magnitude bits
    CL_EDGE,     // e == 158: only -2^31 is representable
    CL_OVF,      // 159 <= e <= 254: out of range
    CL_SPECIAL   // e == 255: infinity or NaN
  } cls_e;

  // Stage 1 decode signals
  logic       a_sign;
  logic [7:0] a_exp;
  logic [22:0] a_frac;
  cls_e       cls_d;
  logic       left_d;
  logic [4:0] shamt_d;

  // Stage 1 registers
  logic        s1_valid;
  logic        s1_sign;
  logic [23:0] s1_mant;
  logic        s1_frac_nz;
  cls_e        s1_cls;
  logic        s1_left;
  logic [4:0]  s1_shamt;

  // Stage 2 result signals
  logic [47:0] rsh;
  logic [31:0] lsh;
  logic        guard;
  logic        sticky;
  logic [31:0] mag;
  logic [31:0] b_d;
  logic        invalid_d;
  logic        inexact_d;

  assign a_sign = a[31];
  assign a_exp  = a[30:23];
  assign a_frac = a[22:0];

  // Classify the exponent and derive the shift direction and distance.
  // Shift distance is only meaningful for CL_NORMAL (left 0..7, right 1..23).
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls_d = CL_NORMAL;
    if (a_exp == 8'd0)             cls_d = CL_ZERO;
    else if (a_exp <= 8'd125)      cls_d = CL_SMALL;
    else if (a_exp == 8'd126)      cls_d = CL_HALF;
    else if (a_exp <= 8'd157)      cls_d = CL_NORMAL;
    else if (a_exp == 8'd158)      cls_d = CL_EDGE;
    else if (a_exp == 8'd255)      cls_d = CL_SPECIAL;
    else                           cls_d = CL_OVF;
    left_d  = (a_exp >= 8'd150);
    shamt_d = left_d ? 5'(a_exp - 8'd150) : 5'(8'd150 - a_exp);
  end

  // Stage 1 datapath: captured whenever the pipe advances; qualified by s1_valid.
  // NOTE: pure datapath registers carry no reset; only the valid chain and the
  // visible outputs must come out of reset in a known state.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign    <= a_sign;
      s1_mant    <= {1'b1, a_frac};
      s1_frac_nz <= (a_frac != 23'd0);
      s1_cls     <= cls_d;
      s1_left    <= left_d;
      s1_shamt   <= shamt_d;
    end
  end

  // Shift, round, sign and saturate the stage 1 operand.
  always_comb begin
    rsh       = {s1_mant, 24'd0} >> s1_shamt;
    lsh       = {8'd0, s1_mant} << s1_shamt;
    guard     = rsh[23];
    sticky    = |rsh[22:0];
    mag       = 32'd0;
    b_d       = 32'd0;
    invalid_d = 1'b0;
    inexact_d = 1'b0;
    unique case (s1_cls)
      CL_ZERO: begin
        inexact_d = s1_frac_nz;
      end
      CL_SMALL: begin
        inexact_d = 1'b1;
      end
      CL_HALF: begin
        inexact_d = 1'b1;
        if (ROUND_MODE == 0) b_d = s1_sign ? 32'hFFFF_FFFF : 32'd1;
      end
      CL_NORMAL: begin
        if (s1_left) begin
          mag = lsh;
        end else begin
          mag       = {8'd0, rsh[47:24]};
          inexact_d = guard | sticky;
          if (ROUND_MODE == 0) mag = mag + {31'd0, guard};
        end
        b_d = s1_sign ? (~mag + 32'd1) : mag;
      end
      CL_EDGE: begin
        if (s1_sign && !s1_frac_nz) begin
          b_d = 32'h8000_0000;
        end else begin
          b_d       = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          invalid_d = 1'b1;
        end
      end
      CL_OVF: begin
        b_d       = s1_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        invalid_d = 1'b1;
      end
      CL_SPECIAL: begin
        // NaN ignores the sign; infinity saturates by sign.
        b_d       = (s1_sign && !s1_frac_nz) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        invalid_d = 1'b1;
      end
      default: begin
        b_d = 32'd0;
      end
    endcase
  end

  // Valid chain and output registers; reset wins over stall, outputs only
  // change when a valid operand leaves stage 1.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      b         <= 32'd0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        b       <= b_d;
        invalid <= invalid_d;
        inexact <= inexact_d;
      end
    end
  end

endmodule
